imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 87 ++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage with a two-entry (output + skid) elastic buffer.
// Decodes one request per cycle into a DATA_W result and counts illegal modes.
module imm_extend_pipe #(
    parameter int DATA_W = 32,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [25:0]       in_imm,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [ERR_W-1:0]  err_cnt
);

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            new_ent, skid_ent;
    logic              skid_valid;
    logic              accept, drain;
    logic [DATA_W-1:0] sx16;
    logic              unused_pc;

    // Only the PC segment above the 256 MB jump region is consumed.
    assign unused_pc = ^in_pc[27:0];

    assign sx16     = {{(DATA_W-16){in_imm[15]}}, in_imm[15:0]};
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = out_valid & out_ready;

    always_comb begin
        new_ent = '0;
        case (in_mode)
            3'd0:    new_ent.data = sx16;
            3'd1:    new_ent.data = {{(DATA_W-16){1'b0}}, in_imm[15:0]};
            3'd2:    new_ent.data = sx16 << 16;
            3'd3:    new_ent.data = {{(DATA_W-5){1'b0}}, in_imm[10:6]};
            3'd4:    new_ent.data = sx16 << 2;
            3'd5:    new_ent.data = {in_pc[DATA_W-1:28], in_imm, 2'b00};
            default: new_ent.err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_ent   <= '0;
            err_cnt    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (drain || !out_valid) begin
                // Skid entry is older than anything arriving now; it goes first.
                if (skid_valid) begin
                    {out_err, out_data} <= skid_ent;
                    out_valid           <= 1'b1;
                    skid_valid          <= 1'b0;
                end else if (accept) begin
                    {out_err, out_data} <= new_ent;
                    out_valid           <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_ent   <= new_ent;
                skid_valid <= 1'b1;
            end
            if (accept && new_ent.err && !(&err_cnt))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
